// File: rtl/logic_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package logic_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } logic_op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand (valid/ready) and result (valid/ready) channels of logic_unit_pipe.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    import logic_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic_op_e        in_op;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_parity;

    // master: operand source and result sink; slave: the logic unit itself
    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_parity
    );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise function of two operands plus zero/parity flags.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic_op_e        op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_PASS: result = a;
            default: result = '0;
        endcase
        zero   = ~|result;
        parity = ^result;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_core with an accumulate mode.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic_op_e        s1_op;
    logic             s1_acc;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_parity;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] eff_b;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_parity;
    logic             stall;

    assign stall        = s2_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    // acc already holds the previous valid beat's result, so back-to-back chains need no bypass
    assign eff_b        = s1_acc ? acc : s1_b;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (eff_b),
        .result (core_result),
        .zero   (core_zero),
        .parity (core_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_AND;
            s1_acc    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_zero   <= 1'b0;
            s2_parity <= 1'b0;
            acc       <= '0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_op    <= bus.in_op;
            s1_acc   <= bus.in_acc;
            s2_valid <= s1_valid;
            // bubbles leave the result fields untouched so they hold while out_valid=0
            if (s1_valid) begin
                s2_result <= core_result;
                s2_zero   <= core_zero;
                s2_parity <= core_parity;
                acc       <= core_result;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_zero   = s2_zero;
    assign bus.out_parity = s2_parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: reference model feeds a queue, monitor pops on each output handshake.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  result;
        logic        zero;
        logic        parity;
        int unsigned tag;
        bit          lat_chk;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  model_acc = 8'h00;
    bit          lat_mode = 1'b0;
    bit          rand_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_fn(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return 8'hFF - a;
            3: return 8'hFF - (a & b);
            4: return 8'hFF - (a | b);
            5: return a ^ b;
            6: return 8'hFF - (a ^ b);
            default: return a;
        endcase
    endfunction

    // Offer one beat and hold it until the DUT shows in_ready; model the result at acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input int op, input bit accm);
        int unsigned n = 0;
        bit          done = 1'b0;
        exp_t        e;
        logic [7:0]  r;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = logic_op_e'(op[2:0]);
        bus.in_acc   = accm;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1 && !rst) begin
                r         = ref_fn(op, a, accm ? model_acc : b);
                model_acc = r;
                e.result  = r;
                e.zero    = (r == 8'h00);
                e.parity  = ($countones(r) % 2) == 1;
                e.tag     = cyc;
                e.lat_chk = lat_mode;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready never rose, got %0d cycles, expected < 1000", n);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare on every output handshake, and check stall behaviour.
    initial begin
        exp_t       e;
        bit         stalled_prev = 1'b0;
        logic [7:0] held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1) begin
                if (stalled_prev) chk("stall_hold", 64'(bus.out_result), 64'(held));
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got result 0x%0h, expected no beat", bus.out_result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'(bus.out_result), 64'(e.result));
                        chk("zero", 64'(bus.out_zero), 64'(e.zero));
                        chk("parity", 64'(bus.out_parity), 64'(e.parity));
                        if (e.lat_chk && !stalled_prev)
                            chk("latency", 64'(cyc - e.tag), 64'd2);
                    end
                end else begin
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                end
                stalled_prev = !bus.out_ready;
                held         = bus.out_result;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_AND;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_result", 64'(bus.out_result), 64'h00);
        chk("reset_out_zero", 64'(bus.out_zero), 64'd0);
        chk("reset_out_parity", 64'(bus.out_parity), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        lat_mode = 1'b1;
        for (int op = 0; op < 8; op++) send(8'hC5, 8'h3A, op, 1'b0);
        lat_mode = 1'b0;
        drain();

        send(8'h0F, 8'h00, 5, 1'b0);
        send(8'hF0, 8'h55, 5, 1'b1);
        send(8'h3C, 8'h00, 0, 1'b1);
        drain();

        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 1'b0);
            end
            begin
                n = 0;
                while (bus.out_valid !== 1'b1 && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        send(8'h5A, 8'h00, 7, 1'b0);
        send(8'hA5, 8'h00, 7, 1'b0);
        rst = 1'b1;
        sb.delete();
        model_acc = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(8'h00, 8'hAB, 1, 1'b1);
        drain();

        send(8'h01, 8'h00, 7, 1'b0);
        send(8'h00, 8'h00, 7, 1'b0);
        drain();

        rand_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_en = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
